btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 158 +++++++++++++++
 tb/tb_btn_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button conditioner: 2-flop sync, per-channel debounce and press pulses.
// Optional auto-repeat on btn_min/btn_sec when AUTO_REPEAT_EN is defined.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CNT = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_start_stop,
  input  logic       btn_reset,
  output logic       btn_min_p,
  output logic       btn_sec_p,
  output logic       btn_start_stop_p,
  output logic       btn_reset_p,
  output logic [3:0] btn_held
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 16;
  localparam logic [CW:0] DB_LIM = (CW+1)'(DEBOUNCE_CNT);

  logic [NCH-1:0] raw_c;
  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] level_q, level_d;
  logic [NCH-1:0] pulse_q, pulse_d;
  logic [NCH-1:0] press_c;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  assign raw_c = {btn_reset, btn_start_stop, btn_sec, btn_min};

  // Debounce: count consecutive mismatch cycles, toggle level on reaching the limit
  always_comb begin : debounce_comb
    logic [CW:0] cnt_inc;
    sync1_d = raw_c;
    sync2_d = sync1_q;
    level_d = level_q;
    press_c = '0;
    cnt_inc = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      cnt_inc  = {1'b0, cnt_q[i]} + (CW+1)'(1);
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_inc == DB_LIM) begin
          level_d[i] = ~level_q[i];
          press_c[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_inc[CW-1:0];
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [CW:0] RD_LIM = (CW+1)'(REPEAT_DELAY);
  localparam logic [CW:0] RR_LIM = (CW+1)'(REPEAT_RATE);

  logic [1:0]    st_q   [2];
  logic [1:0]    st_d   [2];
  logic [CW-1:0] rcnt_q [2];
  logic [CW-1:0] rcnt_d [2];
  logic [1:0]    rep_c;

  // Repeat FSMs for min/sec; a debounced release always wins over a due repeat
  always_comb begin : repeat_comb
    logic [CW:0] rinc;
    rep_c = '0;
    rinc  = '0;
    for (int j = 0; j < 2; j++) begin
      st_d[j]   = st_q[j];
      rcnt_d[j] = rcnt_q[j];
      rinc      = {1'b0, rcnt_q[j]} + (CW+1)'(1);
      case (st_q[j])
        ST_IDLE: begin
          if (press_c[j]) begin
            st_d[j]   = ST_DELAY;
            rcnt_d[j] = '0;
          end
        end
        ST_DELAY: begin
          if (!level_d[j]) begin
            st_d[j]   = ST_IDLE;
            rcnt_d[j] = '0;
          end else if (rinc == RD_LIM) begin
            st_d[j]   = ST_REPEAT;
            rcnt_d[j] = '0;
            rep_c[j]  = 1'b1;
          end else begin
            rcnt_d[j] = rinc[CW-1:0];
          end
        end
        ST_REPEAT: begin
          if (!level_d[j]) begin
            st_d[j]   = ST_IDLE;
            rcnt_d[j] = '0;
          end else if (rinc == RR_LIM) begin
            rcnt_d[j] = '0;
            rep_c[j]  = 1'b1;
          end else begin
            rcnt_d[j] = rinc[CW-1:0];
          end
        end
        default: begin
          st_d[j]   = ST_IDLE;
          rcnt_d[j] = '0;
        end
      endcase
    end
    pulse_d = press_c | {2'b00, rep_c};
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        st_q[j]   <= ST_IDLE;
        rcnt_q[j] <= '0;
      end else begin
        st_q[j]   <= st_d[j];
        rcnt_q[j] <= rcnt_d[j];
      end
    end
  end
`else
  always_comb begin : pulse_comb
    pulse_d = press_c;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_min_p        = pulse_q[0];
  assign btn_sec_p        = pulse_q[1];
  assign btn_start_stop_p = pulse_q[2];
  assign btn_reset_p      = pulse_q[3];
  assign btn_held         = level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: directed scenarios plus random button
// activity, checked cycle by cycle against a behavioural model.
module tb_btn_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_min = 1'b0, btn_sec = 1'b0, btn_start_stop = 1'b0, btn_reset = 1'b0;
  logic btn_min_p, btn_sec_p, btn_start_stop_p, btn_reset_p;
  logic [3:0] btn_held;

  btn_conditioner #(.DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst),
    .btn_min(btn_min), .btn_sec(btn_sec),
    .btn_start_stop(btn_start_stop), .btn_reset(btn_reset),
    .btn_min_p(btn_min_p), .btn_sec_p(btn_sec_p),
    .btn_start_stop_p(btn_start_stop_p), .btn_reset_p(btn_reset_p),
    .btn_held(btn_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: raw samples seen through a 2-cycle delay, plus a window of
  // the last DB synchronized samples since reset.
  int         t = 0;
  logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  logic [3:0] win [DB];
  int         nvalid = 0;
  int         press_t [2];
  bit         active [2];

  task automatic model_step(input logic [3:0] b, input logic r);
    logic [3:0] pulses;
    exp_t e;
    pulses = '0;
    t++;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; nvalid = 0;
      active[0] = 0; active[1] = 0;
    end else begin
      for (int k = DB-1; k > 0; k--) win[k] = win[k-1];
      win[0] = m_s2;
      if (nvalid < DB) nvalid++;
      for (int ch = 0; ch < 4; ch++) begin
        bit flip;
        flip = (nvalid >= DB);
        for (int k = 0; k < DB; k++) if (win[k][ch] == m_lvl[ch]) flip = 0;
        if (flip) begin
          m_lvl[ch] = ~m_lvl[ch];
          if (m_lvl[ch]) pulses[ch] = 1'b1;
`ifdef AUTO_REPEAT_EN
          if (ch < 2) begin
            active[ch]  = m_lvl[ch];
            press_t[ch] = t;
          end
        end else if (ch < 2 && active[ch] && m_lvl[ch]) begin
          int d;
          d = t - press_t[ch];
          if (d == RD || (d > RD && ((d - RD) % RR) == 0)) pulses[ch] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    e.edge_no = t;
    e.val     = {pulses, m_lvl};
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] b, input logic r);
    @(negedge clk);
    {btn_reset, btn_start_stop, btn_sec, btn_min} = b;
    rst = r;
    @(posedge clk);
    model_step(b, r);
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a fresh output vector
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [7:0] act;
        e   = exp_q.pop_front();
        act = {btn_reset_p, btn_start_stop_p, btn_sec_p, btn_min_p, btn_held};
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL outputs@edge%0d got pulses=%b held=%b expected pulses=%b held=%b",
                   e.edge_no, act[7:4], act[3:0], e.val[7:4], e.val[3:0]);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < DB; k++) win[k] = '0;
    active[0] = 0; active[1] = 0; press_t[0] = 0; press_t[1] = 0;

    step(4'b0000, 1'b1); step(4'b0000, 1'b1); step(4'b0000, 1'b1);
    hold(4'b0000, 3);
    // sec press and release
    hold(4'b0010, 12); hold(4'b0000, 10);
    // short glitch then qualifying pulse on start_stop
    hold(4'b0100, 3); hold(4'b0000, 8);
    hold(4'b0100, 4); hold(4'b0000, 10);
    // long holds on min (repeats when enabled) and reset (never repeats)
    hold(4'b0001, 36); hold(4'b0000, 12);
    hold(4'b1000, 36); hold(4'b0000, 12);
    hold(4'b0001, 110); hold(4'b0000, 10);
    // simultaneous press
    hold(4'b1001, 10); hold(4'b0000, 10);
    // reset in the middle of debounce and of repeat with raw held high
    hold(4'b0010, 2); step(4'b0010, 1'b1); step(4'b0010, 1'b1);
    hold(4'b0010, 12); hold(4'b0000, 10);
    hold(4'b0011, 20); step(4'b0011, 1'b1); hold(4'b0011, 15); hold(4'b0000, 10);
    // random activity
    for (int s = 0; s < 150; s++) begin
      logic [3:0] b;
      int len;
      b   = 4'($urandom);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
      if ($urandom_range(0, 24) == 0) begin
        step(b, 1'b1);
        len = len - 1;
      end
      hold(b, len);
    end
    hold(4'b0000, 12);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
